sfp_div_issuer: RTL and testbench

//  Initiator side of the SFP divider handshake (strt_pulse/busy/valid).
//  On a batch command it reads N dividends from an element buffer, issues each one with a shared divisor
//  (the softmax normalisation sum) to the divider, and collects each quotient.

---
 rtl/sfp_pkg.sv | 18 +
 rtl/sfp_div_tmo_ctr.sv | 33 +++
 rtl/sfp_div_issuer.sv | 144 ++++++++++++++
 tb/tb_sfp_div_issuer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP divider issuer: operand width, FSM state encoding
// and the saturation word written on divide-by-zero.
package sfp_pkg;

  localparam int SFP_BW = 20;
  localparam logic [SFP_BW-1:0] SFP_SAT = {SFP_BW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LAT   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WR    = 3'd5,
    ST_DONE  = 3'd6
  } sfp_state_e;

endpackage

// File: rtl/sfp_div_tmo_ctr.sv
// Divider-response timeout counter: synchronous clear, count enable, saturates at TMO-1
// and flags the hit so the issuer can give up on a silent divider.
module sfp_div_tmo_ctr #(
  parameter int TMO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] LAST = TW'(TMO - 1);

  logic [TW-1:0] cnt_r;

  // Wait-cycle counter, held at LAST once reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = (cnt_r == LAST);

endmodule

// File: rtl/sfp_div_issuer.sv
// Initiator for the SFP divider handshake: reads N dividends, divides each by a shared
// sum and writes the quotient back in place, with divide-by-zero and timeout handling.
import sfp_pkg::*;

module sfp_div_issuer #(
  parameter int BW  = SFP_BW,
  parameter int N   = 8,
  parameter int AW  = 3,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [BW-1:0] sum_in,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [BW-1:0] rd_data,
  output logic          div_strt,
  input  logic          div_busy,
  input  logic          div_valid,
  output logic [BW-1:0] div_dividend,
  output logic [BW-1:0] div_divisor,
  input  logic [BW-1:0] div_quot,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [BW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err_div0,
  output logic          err_tmo
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [BW-1:0] SAT_W    = BW'(SFP_SAT);

  sfp_state_e    state_r;
  logic [AW-1:0] idx_r;
  logic [BW-1:0] sum_r;
  logic          tmo_clr_s;
  logic          tmo_en_s;
  logic          tmo_hit_s;

  // The timer only runs while waiting on the divider, so it is zero on the first WAIT cycle.
  assign tmo_clr_s = (state_r != ST_WAIT);
  assign tmo_en_s  = (state_r == ST_WAIT);

  sfp_div_tmo_ctr #(.TMO(TMO)) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr_s),
    .en  (tmo_en_s),
    .hit (tmo_hit_s)
  );

  // Batch sequencer; strobes are set on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      sum_r        <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      div_strt     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_div0     <= 1'b0;
      err_tmo      <= 1'b0;
    end else begin
      rd_en    <= 1'b0;
      div_strt <= 1'b0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            sum_r    <= sum_in;
            idx_r    <= '0;
            busy     <= 1'b1;
            err_div0 <= 1'b0;
            err_tmo  <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            state_r  <= ST_RD;
          end
        end
        ST_RD: state_r <= ST_LAT;
        ST_LAT: begin
          // A zero divisor saturates every element without touching the divider.
          if (sum_r == '0) begin
            wr_en    <= 1'b1;
            wr_addr  <= idx_r;
            wr_data  <= SAT_W;
            err_div0 <= 1'b1;
            state_r  <= ST_WR;
          end else begin
            div_dividend <= rd_data;
            div_divisor  <= sum_r;
            state_r      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!div_busy) begin
            div_strt <= 1'b1;
            state_r  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= idx_r;
            wr_data <= div_quot;
            state_r <= ST_WR;
          end else if (tmo_hit_s) begin
            wr_en   <= 1'b1;
            wr_addr <= idx_r;
            wr_data <= '0;
            err_tmo <= 1'b1;
            state_r <= ST_WR;
          end
        end
        ST_WR: begin
          if (idx_r == LAST_IDX) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + AW'(1);
            rd_en   <= 1'b1;
            rd_addr <= idx_r + AW'(1);
            state_r <= ST_RD;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_div_issuer.sv
// Scoreboard bench for sfp_div_issuer with a behavioural 12-cycle integer divider
// and a small element buffer model.
module tb_sfp_div_issuer;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [19:0] sum_in;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [19:0] rd_data = 20'd0;
  logic        div_strt, div_busy, div_valid;
  logic [19:0] div_dividend, div_divisor;
  logic [19:0] div_quot = 20'd0;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [19:0] wr_data;
  logic        busy, done, err_div0, err_tmo;

  always #5 clk = ~clk;

  sfp_div_issuer dut (
    .clk(clk), .rst(rst), .go(go), .sum_in(sum_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .div_strt(div_strt), .div_busy(div_busy), .div_valid(div_valid),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quot(div_quot),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_div0(err_div0), .err_tmo(err_tmo)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [19:0] mem [8];

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // behavioural divider
  logic        m_busy = 1'b0, m_valid = 1'b0;
  logic        force_busy = 1'b0, spur_valid = 1'b0;
  logic [19:0] m_a = 20'd0, m_b = 20'd0;
  int          m_cnt = 0;
  int          hang_elem = -1;
  int          strt_cnt = 0, done_cnt = 0, cyc = 0, strt_cyc = 0;
  logic [19:0] cur_sum = 20'd0;

  assign div_busy  = m_busy | force_busy;
  assign div_valid = m_valid | spur_valid;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_valid <= 1'b0;
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy   <= 1'b0;
        m_valid  <= 1'b1;
        div_quot <= (m_b == 20'd0) ? 20'hFFFFF : m_a / m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (div_strt && (strt_cnt - 1 != hang_elem)) begin
      m_busy <= 1'b1;
      m_cnt  <= 12;
      m_a    <= div_dividend;
      m_b    <= div_divisor;
    end
  end

  typedef struct {
    logic [2:0]  a;
    logic [19:0] d;
  } wr_t;
  wr_t exp_q[$];

  // output monitor and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (div_strt) begin
        if (strt_cnt < 8) chk_eq("strt_dividend", div_dividend, mem[strt_cnt]);
        chk_eq("strt_divisor", div_divisor, cur_sum);
        strt_cyc = cyc;
        strt_cnt++;
      end
      if (m_valid) begin
        chk_eq("hold_dividend", div_dividend, m_a);
        chk_eq("hold_divisor", div_divisor, m_b);
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk_eq("wr_unexpected", exp_q.size(), 1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk_eq("wr_addr", wr_addr, e.a);
          chk_eq("wr_data", wr_data, e.d);
          if (int'(wr_addr) == hang_elem) chk_eq("tmo_latency", cyc - strt_cyc, 64);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_batch(input logic [19:0] s);
    wr_t e;
    cur_sum  = s;
    strt_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      e.a = 3'(i);
      if (s == 20'd0)         e.d = 20'hFFFFF;
      else if (i == hang_elem) e.d = 20'd0;
      else                     e.d = mem[i] / s;
      exp_q.push_back(e);
    end
    @(negedge clk);
    go = 1'b1;
    sum_in = s;
    @(negedge clk);
    go = 1'b0;
    sum_in = 20'h12345;
    chk_eq("busy_after_go", busy, 1);
  endtask

  task automatic wait_done(input string tag, input bit spam);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (spam) begin
        go = (k % 5 == 2);
        sum_in = 20'd0;
        spur_valid = rd_en;
      end
    end
    go = 1'b0;
    spur_valid = 1'b0;
    chk_eq({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk_eq({tag, "_done_once"}, done_cnt, 1);
    chk_eq({tag, "_busy_low"}, busy, 0);
    chk_eq({tag, "_all_written"}, exp_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk_eq({tag, "_ctrl"}, {rd_en, rd_addr, div_strt, wr_en, wr_addr, busy, done, err_div0, err_tmo}, 0);
    chk_eq({tag, "_dividend"}, div_dividend, 0);
    chk_eq({tag, "_divisor"}, div_divisor, 0);
    chk_eq({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    logic [19:0] d0;
    mem[0] = 20'd86;   mem[1] = 20'd40;   mem[2] = 20'd123;     mem[3] = 20'd7;
    mem[4] = 20'd1000; mem[5] = 20'd0;    mem[6] = 20'd1048575; mem[7] = 20'd55;
    rst = 1'b0; go = 1'b0; sum_in = 20'd0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_eq("idle_after_reset", busy, 0);

    // 1: plain batch
    start_batch(20'd4);
    wait_done("s1", 1'b0);
    chk_eq("s1_strt_cnt", strt_cnt, 8);
    chk_eq("s1_err", {err_div0, err_tmo}, 0);

    // 2: divider busy stalls the first issue
    start_batch(20'd4);
    force_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 5) d0 = div_dividend;
    end
    chk_eq("s2_stable_dividend", div_dividend, d0);
    chk_eq("s2_dividend_val", div_dividend, mem[0]);
    chk_eq("s2_no_strt_while_busy", strt_cnt, 0);
    force_busy = 1'b0;
    wait_done("s2", 1'b0);
    chk_eq("s2_strt_cnt", strt_cnt, 8);

    // 3: divide by zero
    start_batch(20'd0);
    wait_done("s3", 1'b0);
    chk_eq("s3_strt_cnt", strt_cnt, 0);
    chk_eq("s3_err_div0", err_div0, 1);
    chk_eq("s3_err_tmo", err_tmo, 0);

    // 4: silent divider on element 2
    hang_elem = 2;
    start_batch(20'd4);
    wait_done("s4", 1'b0);
    chk_eq("s4_err_tmo", err_tmo, 1);
    chk_eq("s4_err_div0_cleared", err_div0, 0);
    hang_elem = -1;

    // 5: reset during WAIT of element 3
    start_batch(20'd4);
    for (int k = 0; k < 2000 && strt_cnt < 4; k++) @(negedge clk);
    chk_eq("s5_reached_elem3", strt_cnt, 4);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("s5_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("s5_idle_after_reset", busy, 0);
    chk_eq("s5_no_done", done_cnt, 0);
    start_batch(20'd4);
    wait_done("s5b", 1'b0);
    chk_eq("s5b_strt_cnt", strt_cnt, 8);

    // 6: go spam while busy and spurious valid in RD
    start_batch(20'd4);
    wait_done("s6", 1'b1);
    chk_eq("s6_strt_cnt", strt_cnt, 8);
    chk_eq("s6_err", {err_div0, err_tmo}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
